um_load_ctrl: RTL

Controller for the unsorted-element memory (UM) of the comparison-free sorter. It accepts a valid/ready input stream and writes elements into consecutive UM addresses. It then starts the sort core and owns the UM address mux while the core reads elements back. After the core reports completion it returns to idle, optionally zero-filling the UM first. It sits between the sorter's top-level input port and the UM, and is the only driver of the UM write enable and address.

---
 rtl/um_load_ctrl_if.sv | 54 +++++
 rtl/um_load_ctrl.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/um_load_ctrl_if.sv
// -----------------------------------------------------------------------------
// um_load_ctrl_if
// Bundles the signals of the UM load controller: the element input stream,
// the UM write/address port, the sort-core handshake and the status outputs.
//
// Modports:
//   slave  - the controller itself (consumes the stream, drives UM and status)
//   master - the surrounding logic (drives the stream and the core requests)
//
// Signals:
//   s_valid/s_data/s_last -> s_ready   element input stream
//   um_we/um_addr/um_wdata             UM write enable, address, write data
//   start                              one-cycle pulse to the sort core
//   count                              elements loaded in the current set
//   core_rd_req/core_rd_addr -> core_rd_gnt   core read handshake
//   core_done                          core finished with the UM
//   rd_oob                             pulse: a read beyond count was refused
//   busy                               controller not idle
// -----------------------------------------------------------------------------
interface um_load_ctrl_if #(
  parameter int DATA_WIDTH       = 8,
  parameter int LOG2_ELEMENT_NUM = 4
);
  logic                          s_valid;
  logic [DATA_WIDTH-1:0]         s_data;
  logic                          s_last;
  logic                          s_ready;

  logic                          um_we;
  logic [LOG2_ELEMENT_NUM-1:0]   um_addr;
  logic [DATA_WIDTH-1:0]         um_wdata;

  logic                          start;
  logic [LOG2_ELEMENT_NUM:0]     count;

  logic                          core_rd_req;
  logic [LOG2_ELEMENT_NUM-1:0]   core_rd_addr;
  logic                          core_rd_gnt;
  logic                          core_done;
  logic                          rd_oob;
  logic                          busy;

  modport slave (
    input  s_valid, s_data, s_last, core_rd_req, core_rd_addr, core_done,
    output s_ready, um_we, um_addr, um_wdata, start, count, core_rd_gnt,
           rd_oob, busy
  );

  modport master (
    output s_valid, s_data, s_last, core_rd_req, core_rd_addr, core_done,
    input  s_ready, um_we, um_addr, um_wdata, start, count, core_rd_gnt,
           rd_oob, busy
  );
endinterface

// File: rtl/um_load_ctrl.sv
// -----------------------------------------------------------------------------
// um_load_ctrl
// Loads an element stream into consecutive addresses of the unsorted-element
// memory (UM), starts the sort core, then hands the UM address port to the
// core for bounds-checked reads until the core reports completion.
//
// Optional feature: define UM_LOAD_CTRL_AUTOCLEAR_EN to zero-fill the whole UM
// (ELEMENT_NUM writes through a CLEAR state) before returning to idle.
//
// Ports:
//   clk  - clock, rising edge
//   rst  - synchronous, active-high reset
//   bus  - um_load_ctrl_if.slave: input stream, UM write/address port,
//          sort-core read handshake, start/count/rd_oob/busy status
// -----------------------------------------------------------------------------
module um_load_ctrl #(
  parameter int DATA_WIDTH       = 8,
  parameter int ELEMENT_NUM      = 16,
  parameter int LOG2_ELEMENT_NUM = 4
) (
  input logic           clk,
  input logic           rst,
  um_load_ctrl_if.slave bus
);

  localparam int AW = LOG2_ELEMENT_NUM;
  localparam int CW = LOG2_ELEMENT_NUM + 1;
  localparam logic [AW-1:0] LAST_ADDR = AW'(ELEMENT_NUM - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SORT  = 2'd2
`ifdef UM_LOAD_CTRL_AUTOCLEAR_EN
    , ST_CLEAR = 2'd3
`endif
  } state_t;

  state_t          state_q;
  logic [AW-1:0]   wr_ptr_q;
  logic [CW-1:0]   count_q;
  logic            start_q;
  logic            rd_oob_q;
`ifdef UM_LOAD_CTRL_AUTOCLEAR_EN
  logic [AW-1:0]   clr_ptr_q;
`endif

  logic            load_phase;
  logic            accept;
  logic            close_set;
  logic            sorting;
  logic            rd_in_range;

  logic                  um_we_c;
  logic [AW-1:0]         um_addr_c;
  logic [DATA_WIDTH-1:0] um_wdata_c;

  // IDLE and LOAD both accept beats; wr_ptr_q is held at 0 while idle, so
  // the first beat of a set always lands at address 0.
  assign load_phase  = (state_q == ST_IDLE) || (state_q == ST_LOAD);
  assign accept      = bus.s_valid & load_phase;
  // A full UM closes the set even without s_last, so wr_ptr never wraps.
  assign close_set   = accept & (bus.s_last | (wr_ptr_q == LAST_ADDR));
  assign sorting     = (state_q == ST_SORT);
  // Zero-extend the address so an address equal to ELEMENT_NUM-1 compares
  // correctly against a count of ELEMENT_NUM.
  assign rd_in_range = ({1'b0, bus.core_rd_addr} < count_q);

  // UM port mux: stream write path while loading, core address while
  // sorting, zero-fill sweep while clearing.
  always_comb begin
    um_we_c    = 1'b0;
    um_addr_c  = wr_ptr_q;
    um_wdata_c = bus.s_data;
    case (state_q)
      ST_IDLE, ST_LOAD: begin
        um_we_c = accept;
      end
      ST_SORT: begin
        um_addr_c = bus.core_rd_addr;
      end
`ifdef UM_LOAD_CTRL_AUTOCLEAR_EN
      ST_CLEAR: begin
        um_we_c    = 1'b1;
        um_addr_c  = clr_ptr_q;
        um_wdata_c = '0;
      end
`endif
      default: begin
        um_we_c = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      start_q   <= 1'b0;
      rd_oob_q  <= 1'b0;
`ifdef UM_LOAD_CTRL_AUTOCLEAR_EN
      clr_ptr_q <= '0;
`endif
    end else begin
      start_q  <= 1'b0;
      // Only refused requests made while sorting report out-of-bounds.
      rd_oob_q <= sorting & bus.core_rd_req & ~rd_in_range;

      case (state_q)
        ST_IDLE, ST_LOAD: begin
          if (accept) begin
            // count is 0 in IDLE, so the first beat yields count = 1.
            count_q <= count_q + CW'(1);
            if (close_set) begin
              state_q  <= ST_SORT;
              start_q  <= 1'b1;
              wr_ptr_q <= '0;
            end else begin
              state_q  <= ST_LOAD;
              wr_ptr_q <= wr_ptr_q + AW'(1);
            end
          end
        end

        ST_SORT: begin
          if (bus.core_done) begin
`ifdef UM_LOAD_CTRL_AUTOCLEAR_EN
            state_q   <= ST_CLEAR;
            clr_ptr_q <= '0;
`else
            state_q   <= ST_IDLE;
            count_q   <= '0;
`endif
          end
        end

`ifdef UM_LOAD_CTRL_AUTOCLEAR_EN
        ST_CLEAR: begin
          if (clr_ptr_q == LAST_ADDR) begin
            state_q   <= ST_IDLE;
            count_q   <= '0;
            clr_ptr_q <= '0;
          end else begin
            clr_ptr_q <= clr_ptr_q + AW'(1);
          end
        end
`endif

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.s_ready     = load_phase;
  assign bus.um_we       = um_we_c;
  assign bus.um_addr     = um_addr_c;
  assign bus.um_wdata    = um_wdata_c;
  assign bus.start       = start_q;
  assign bus.count       = count_q;
  assign bus.core_rd_gnt = sorting & bus.core_rd_req & rd_in_range;
  assign bus.rd_oob      = rd_oob_q;
  assign bus.busy        = (state_q != ST_IDLE);

endmodule
